// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI slave backed by 2^DEPTH_LOG2 x 256-bit words (ports: clock/reset, AW/W/B write channels, AR/R read channels).
module axi_mem_slave #(
  parameter int DEPTH_LOG2 = 8,
  parameter int ADDR_W = 33
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_s_axi_AWVALID,
  output logic              io_s_axi_AWREADY,
  input  logic [ADDR_W-1:0] io_s_axi_AWADDR,
  input  logic [3:0]        io_s_axi_AWLEN,
  input  logic [1:0]        io_s_axi_AWBURST,
  input  logic              io_s_axi_WVALID,
  output logic              io_s_axi_WREADY,
  input  logic [255:0]      io_s_axi_WDATA,
  input  logic [31:0]       io_s_axi_WSTRB,
  input  logic              io_s_axi_WLAST,
  output logic              io_s_axi_BVALID,
  input  logic              io_s_axi_BREADY,
  output logic [1:0]        io_s_axi_BRESP,
  input  logic              io_s_axi_ARVALID,
  output logic              io_s_axi_ARREADY,
  input  logic [ADDR_W-1:0] io_s_axi_ARADDR,
  input  logic [3:0]        io_s_axi_ARLEN,
  input  logic [1:0]        io_s_axi_ARBURST,
  output logic              io_s_axi_RVALID,
  input  logic              io_s_axi_RREADY,
  output logic [255:0]      io_s_axi_RDATA,
  output logic              io_s_axi_RLAST,
  output logic [1:0]        io_s_axi_RRESP
);
  localparam int DL = DEPTH_LOG2;
  localparam logic [0:0] R_IDLE = 1'b0, R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  logic [255:0] mem_q [1<<DL];
  logic en_q;
  logic [0:0] r_state_q, r_state_d;
  logic [DL-1:0] r_idx_q, r_idx_d;
  logic [3:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic r_err_q, r_err_d, r_fix_q, r_fix_d;
  logic [255:0] rdata_q, rdata_d;
  logic [1:0] w_state_q, w_state_d;
  logic [DL-1:0] w_idx_q, w_idx_d;
  logic [3:0] w_len_q, w_len_d;
  logic [4:0] w_cnt_q, w_cnt_d;
  logic w_err_q, w_err_d, w_fix_q, w_fix_d, bresp_q, bresp_d;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_en;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{io_s_axi_AWADDR[ADDR_W-1:DL+5], io_s_axi_AWADDR[4:0],
                              io_s_axi_ARADDR[ADDR_W-1:DL+5], io_s_axi_ARADDR[4:0]};
  // en_q keeps both address channels closed while reset is held.
  assign io_s_axi_ARREADY = en_q & (r_state_q == R_IDLE);
  assign io_s_axi_RVALID = r_state_q == R_BURST;
  assign io_s_axi_RLAST = io_s_axi_RVALID & (r_cnt_q == r_len_q);
  assign io_s_axi_RRESP = {r_err_q, 1'b0};
  assign io_s_axi_RDATA = rdata_q;
  assign io_s_axi_AWREADY = en_q & (w_state_q == W_IDLE);
  assign io_s_axi_WREADY = w_state_q == W_DATA;
  assign io_s_axi_BVALID = w_state_q == W_RESP;
  assign io_s_axi_BRESP = {bresp_q, 1'b0};
  assign ar_hs = io_s_axi_ARVALID & io_s_axi_ARREADY;
  assign r_hs = io_s_axi_RVALID & io_s_axi_RREADY;
  assign aw_hs = io_s_axi_AWVALID & io_s_axi_AWREADY;
  assign w_hs = io_s_axi_WVALID & io_s_axi_WREADY;
  assign b_hs = io_s_axi_BVALID & io_s_axi_BREADY;
  // Beats past AWLEN and error bursts never touch memory.
  assign wr_en = reset & w_hs & ~w_err_q & (w_cnt_q <= {1'b0, w_len_q});
  // RDATA is registered from the pre-write array contents, which gives read-first
  // behaviour and keeps the beat stable under backpressure.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d = r_idx_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q;
    r_err_d = r_err_q;
    r_fix_d = r_fix_q;
    rdata_d = rdata_q;
    if (ar_hs) begin
      r_state_d = R_BURST;
      r_idx_d = io_s_axi_ARADDR[DL+4:5];
      r_len_d = io_s_axi_ARLEN;
      r_cnt_d = '0;
      r_err_d = io_s_axi_ARBURST[1];
      r_fix_d = io_s_axi_ARBURST == 2'b00;
      rdata_d = io_s_axi_ARBURST[1] ? '0 : mem_q[io_s_axi_ARADDR[DL+4:5]];
    end else if (r_hs) begin
      if (io_s_axi_RLAST) begin
        r_state_d = R_IDLE;
      end else begin
        r_idx_d = r_fix_q ? r_idx_q : r_idx_q + DL'(1);
        r_cnt_d = r_cnt_q + 4'd1;
        rdata_d = r_err_q ? '0 : mem_q[r_idx_d];
      end
    end
  end
  // w_cnt_q saturates at 16, which is already past any AWLEN.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d = w_idx_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    w_err_d = w_err_q;
    w_fix_d = w_fix_q;
    bresp_d = bresp_q;
    if (aw_hs) begin
      w_state_d = W_DATA;
      w_idx_d = io_s_axi_AWADDR[DL+4:5];
      w_len_d = io_s_axi_AWLEN;
      w_cnt_d = '0;
      w_err_d = io_s_axi_AWBURST[1];
      w_fix_d = io_s_axi_AWBURST == 2'b00;
    end else if (w_hs) begin
      w_cnt_d = w_cnt_q[4] ? w_cnt_q : w_cnt_q + 5'd1;
      w_idx_d = w_fix_q ? w_idx_q : w_idx_q + DL'(1);
      if (io_s_axi_WLAST) begin
        w_state_d = W_RESP;
        bresp_d = w_err_q | (w_cnt_q != {1'b0, w_len_q});
      end
    end else if (b_hs) begin
      w_state_d = W_IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      en_q <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      r_err_q <= 1'b0;
      r_fix_q <= 1'b0;
      rdata_q <= '0;
      w_state_q <= W_IDLE;
      w_idx_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
      w_fix_q <= 1'b0;
      bresp_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
      r_state_q <= r_state_d;
      r_idx_q <= r_idx_d;
      r_len_q <= r_len_d;
      r_cnt_q <= r_cnt_d;
      r_err_q <= r_err_d;
      r_fix_q <= r_fix_d;
      rdata_q <= rdata_d;
      w_state_q <= w_state_d;
      w_idx_q <= w_idx_d;
      w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;
      w_err_q <= w_err_d;
      w_fix_q <= w_fix_d;
      bresp_q <= bresp_d;
    end
  end
  always_ff @(posedge clock) begin
    if (wr_en)
      for (int i = 0; i < 32; i++)
        if (io_s_axi_WSTRB[i]) mem_q[w_idx_q][8*i +: 8] <= io_s_axi_WDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized self-checking bench for axi_mem_slave against a word-array reference model.
module tb_axi_mem_slave;
  localparam int AW = 33;
  localparam int NW = 256;
  logic clock = 0, reset = 0;
  logic io_s_axi_AWVALID = 0, io_s_axi_AWREADY;
  logic [AW-1:0] io_s_axi_AWADDR = '0;
  logic [3:0] io_s_axi_AWLEN = '0;
  logic [1:0] io_s_axi_AWBURST = '0;
  logic io_s_axi_WVALID = 0, io_s_axi_WREADY;
  logic [255:0] io_s_axi_WDATA = '0;
  logic [31:0] io_s_axi_WSTRB = '0;
  logic io_s_axi_WLAST = 0;
  logic io_s_axi_BVALID, io_s_axi_BREADY = 0;
  logic [1:0] io_s_axi_BRESP;
  logic io_s_axi_ARVALID = 0, io_s_axi_ARREADY;
  logic [AW-1:0] io_s_axi_ARADDR = '0;
  logic [3:0] io_s_axi_ARLEN = '0;
  logic [1:0] io_s_axi_ARBURST = '0;
  logic io_s_axi_RVALID, io_s_axi_RREADY = 0;
  logic [255:0] io_s_axi_RDATA;
  logic io_s_axi_RLAST;
  logic [1:0] io_s_axi_RRESP;

  axi_mem_slave #(.DEPTH_LOG2(8), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .io_s_axi_AWVALID(io_s_axi_AWVALID), .io_s_axi_AWREADY(io_s_axi_AWREADY),
    .io_s_axi_AWADDR(io_s_axi_AWADDR), .io_s_axi_AWLEN(io_s_axi_AWLEN), .io_s_axi_AWBURST(io_s_axi_AWBURST),
    .io_s_axi_WVALID(io_s_axi_WVALID), .io_s_axi_WREADY(io_s_axi_WREADY),
    .io_s_axi_WDATA(io_s_axi_WDATA), .io_s_axi_WSTRB(io_s_axi_WSTRB), .io_s_axi_WLAST(io_s_axi_WLAST),
    .io_s_axi_BVALID(io_s_axi_BVALID), .io_s_axi_BREADY(io_s_axi_BREADY), .io_s_axi_BRESP(io_s_axi_BRESP),
    .io_s_axi_ARVALID(io_s_axi_ARVALID), .io_s_axi_ARREADY(io_s_axi_ARREADY),
    .io_s_axi_ARADDR(io_s_axi_ARADDR), .io_s_axi_ARLEN(io_s_axi_ARLEN), .io_s_axi_ARBURST(io_s_axi_ARBURST),
    .io_s_axi_RVALID(io_s_axi_RVALID), .io_s_axi_RREADY(io_s_axi_RREADY), .io_s_axi_RDATA(io_s_axi_RDATA),
    .io_s_axi_RLAST(io_s_axi_RLAST), .io_s_axi_RRESP(io_s_axi_RRESP)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0, wready_cycles = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (io_s_axi_WREADY) wready_cycles <= wready_cycles + 1;
  end

  logic [255:0] model [NW];
  logic [255:0] wq_data[$];
  logic [31:0] wq_strb[$];
  logic [255:0] rq_data[$];
  logic rq_last[$];
  logic [1:0] rq_resp[$];
  int rq_cyc[$];
  logic [1:0] last_bresp;

  function automatic int widx(input logic [AW-1:0] a, input int k, input logic [1:0] burst);
    return burst == 2'b00 ? int'((a >> 5) % NW) : int'(((a >> 5) + AW'(k)) % NW);
  endfunction

  function automatic logic [255:0] exp_rd(input logic [AW-1:0] a, input int k, input logic [1:0] burst);
    return burst[1] ? '0 : model[widx(a, k, burst)];
  endfunction

  function automatic logic [255:0] rnd_word();
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [3:0] len, input logic [1:0] burst,
                             output logic [1:0] resp);
    for (int k = 0; k < wq_data.size(); k++)
      if (!burst[1] && k <= int'(len))
        for (int b = 0; b < 32; b++)
          if (wq_strb[k][b]) model[widx(a, k, burst)][8*b +: 8] = wq_data[k][8*b +: 8];
    resp = (burst[1] || wq_data.size() != int'(len) + 1) ? 2'b10 : 2'b00;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] len, input logic [1:0] burst);
    int t;
    bit to = 0;
    io_s_axi_AWADDR = a; io_s_axi_AWLEN = len; io_s_axi_AWBURST = burst; io_s_axi_AWVALID = 1;
    t = 0;
    while (!io_s_axi_AWREADY && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) to = 1;
    @(negedge clock);
    io_s_axi_AWVALID = 0;
    for (int k = 0; k < wq_data.size(); k++) begin
      io_s_axi_WDATA = wq_data[k]; io_s_axi_WSTRB = wq_strb[k];
      io_s_axi_WLAST = k == wq_data.size() - 1; io_s_axi_WVALID = 1;
      t = 0;
      while (!io_s_axi_WREADY && t < 50) begin @(negedge clock); t++; end
      if (t >= 50) to = 1;
      @(negedge clock);
    end
    io_s_axi_WVALID = 0; io_s_axi_WLAST = 0; io_s_axi_BREADY = 1;
    t = 0;
    while (!io_s_axi_BVALID && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) to = 1;
    last_bresp = io_s_axi_BRESP;
    @(negedge clock);
    io_s_axi_BREADY = 0;
    checks++;
    if (to) begin failures++; $display("FAIL write_handshake timeout addr=%h", a); end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [3:0] len, input logic [1:0] burst, input bit rnd);
    int t;
    bit to = 0, done = 0;
    rq_data.delete(); rq_last.delete(); rq_resp.delete(); rq_cyc.delete();
    io_s_axi_ARADDR = a; io_s_axi_ARLEN = len; io_s_axi_ARBURST = burst; io_s_axi_ARVALID = 1;
    t = 0;
    while (!io_s_axi_ARREADY && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) to = 1;
    @(negedge clock);
    io_s_axi_ARVALID = 0;
    io_s_axi_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    t = 0;
    while (!done && t < 200) begin
      if (io_s_axi_RVALID && io_s_axi_RREADY) begin
        rq_data.push_back(io_s_axi_RDATA); rq_last.push_back(io_s_axi_RLAST);
        rq_resp.push_back(io_s_axi_RRESP); rq_cyc.push_back(cyc);
        if (io_s_axi_RLAST || rq_data.size() > 16) done = 1;
      end
      @(negedge clock);
      io_s_axi_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    io_s_axi_RREADY = 0;
    checks++;
    if (to || !done) begin failures++; $display("FAIL read_handshake timeout addr=%h", a); end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({io_s_axi_AWREADY, io_s_axi_ARREADY, io_s_axi_WREADY} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b want=000", {io_s_axi_AWREADY, io_s_axi_ARREADY, io_s_axi_WREADY});
    end
    checks++;
    if ({io_s_axi_RVALID, io_s_axi_RLAST, io_s_axi_BVALID} !== 3'b000) begin
      failures++; $display("FAIL reset_valid got=%b want=000", {io_s_axi_RVALID, io_s_axi_RLAST, io_s_axi_BVALID});
    end
    checks++;
    if ({io_s_axi_RRESP, io_s_axi_BRESP} !== 4'b0000 || io_s_axi_RDATA !== '0) begin
      failures++; $display("FAIL reset_data resp=%b rdata=%h want zero", {io_s_axi_RRESP, io_s_axi_BRESP}, io_s_axi_RDATA);
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if ({io_s_axi_ARREADY, io_s_axi_AWREADY, io_s_axi_WREADY} !== 3'b110) begin
      failures++; $display("FAIL reset_release got=%b want=110", {io_s_axi_ARREADY, io_s_axi_AWREADY, io_s_axi_WREADY});
    end
  endtask

  task automatic test_fill();
    logic [1:0] e;
    for (int f = 0; f < 16; f++) begin
      wq_data.delete(); wq_strb.delete();
      for (int k = 0; k < 16; k++) begin wq_data.push_back(rnd_word()); wq_strb.push_back('1); end
      model_write(AW'(f * 16 * 32), 4'd15, 2'b01, e);
      do_write(AW'(f * 16 * 32), 4'd15, 2'b01);
      checks++;
      if (last_bresp !== e) begin failures++; $display("FAIL fill_bresp got=%b want=%b", last_bresp, e); end
    end
  endtask

  task automatic test_single_write();
    logic [255:0] p;
    logic [1:0] e;
    int w0;
    for (int b = 0; b < 32; b++) p[8*b +: 8] = 8'(b % 2 ? 8'h11 : 8'h08) + 8'(b);
    wq_data = '{p}; wq_strb = '{'1};
    model_write(33'h100, 4'd0, 2'b01, e);
    w0 = wready_cycles;
    do_write(33'h100, 4'd0, 2'b01);
    checks++;
    if (wready_cycles - w0 != 1) begin failures++; $display("FAIL single_wready_cycles got=%0d want=1", wready_cycles - w0); end
    checks++;
    if (last_bresp !== 2'b00) begin failures++; $display("FAIL single_bresp got=%b want=00", last_bresp); end
    do_read(33'h100, 4'd0, 2'b01, 0);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== p || rq_last[0] !== 1'b1 || rq_resp[0] !== 2'b00) begin
      failures++; $display("FAIL single_readback beats=%0d got=%h want=%h", rq_data.size(), rq_data.size() ? rq_data[0] : '0, p);
    end
  endtask

  task automatic test_incr_read();
    do_read(33'h20, 4'd1, 2'b01, 0);
    checks++;
    if (rq_data.size() != 2) begin failures++; $display("FAIL incr_beats got=%0d want=2", rq_data.size()); end
    else begin
      checks++;
      if (rq_data[0] !== model[1] || rq_data[1] !== model[2]) begin
        failures++; $display("FAIL incr_data got=%h,%h want=%h,%h", rq_data[0], rq_data[1], model[1], model[2]);
      end
      checks++;
      if (rq_last[0] !== 1'b0 || rq_last[1] !== 1'b1) begin failures++; $display("FAIL incr_rlast got=%b%b want=01", rq_last[0], rq_last[1]); end
      checks++;
      if (rq_cyc[1] - rq_cyc[0] != 1) begin failures++; $display("FAIL incr_bubble gap=%0d want=1", rq_cyc[1] - rq_cyc[0]); end
    end
    checks++;
    if (io_s_axi_ARREADY !== 1'b1) begin failures++; $display("FAIL incr_arready_after got=%b want=1", io_s_axi_ARREADY); end
  endtask

  task automatic test_backpressure();
    logic [255:0] got[$];
    logic [255:0] hd;
    logic hl;
    int t;
    io_s_axi_ARADDR = 33'h440; io_s_axi_ARLEN = 4'd3; io_s_axi_ARBURST = 2'b01; io_s_axi_ARVALID = 1;
    t = 0;
    while (!io_s_axi_ARREADY && t < 50) begin @(negedge clock); t++; end
    @(negedge clock);
    io_s_axi_ARVALID = 0; io_s_axi_RREADY = 1;
    while (!io_s_axi_RVALID && t < 50) begin @(negedge clock); t++; end
    got.push_back(io_s_axi_RDATA);
    @(negedge clock);
    io_s_axi_RREADY = 0;
    hd = io_s_axi_RDATA; hl = io_s_axi_RLAST;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (io_s_axi_RVALID !== 1'b1 || io_s_axi_RDATA !== hd || io_s_axi_RLAST !== hl) begin
        failures++; $display("FAIL bp_hold cycle=%0d rvalid=%b rdata=%h want=%h", s, io_s_axi_RVALID, io_s_axi_RDATA, hd);
      end
      @(negedge clock);
    end
    io_s_axi_RREADY = 1;
    while (t < 100) begin
      if (io_s_axi_RVALID) begin
        got.push_back(io_s_axi_RDATA);
        if (io_s_axi_RLAST) begin @(negedge clock); break; end
      end
      @(negedge clock); t++;
    end
    io_s_axi_RREADY = 0;
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL bp_beats got=%0d want=4", got.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== model[34 + k]) begin failures++; $display("FAIL bp_data beat=%0d got=%h want=%h", k, got[k], model[34 + k]); end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] e;
    logic [255:0] want;
    want = {{28{8'hFF}}, 32'h0};
    wq_data = '{'1}; wq_strb = '{'1};
    model_write(33'h0A60, 4'd0, 2'b01, e);
    do_write(33'h0A60, 4'd0, 2'b01);
    wq_data = '{'0}; wq_strb = '{32'h0000000F};
    model_write(33'h0A60, 4'd0, 2'b01, e);
    do_write(33'h0A60, 4'd0, 2'b01);
    do_read(33'h0A60, 4'd0, 2'b01, 0);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== want) begin
      failures++; $display("FAIL strobe_readback got=%h want=%h", rq_data.size() ? rq_data[0] : '0, want);
    end
  endtask

  task automatic test_errors();
    logic [1:0] e;
    io_s_axi_WVALID = 1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (io_s_axi_WREADY !== 1'b0) begin failures++; $display("FAIL early_wvalid wready=%b want=0", io_s_axi_WREADY); end
      @(negedge clock);
    end
    io_s_axi_WVALID = 0;
    wq_data = '{rnd_word()}; wq_strb = '{'1};
    model_write(33'h0C00, 4'd1, 2'b01, e);
    do_write(33'h0C00, 4'd1, 2'b01);
    checks++;
    if (last_bresp !== 2'b10) begin failures++; $display("FAIL short_burst_bresp got=%b want=10", last_bresp); end
    wq_data = '{rnd_word(), rnd_word(), rnd_word()}; wq_strb = '{'1, '1, '1};
    model_write(33'h0D00, 4'd0, 2'b01, e);
    do_write(33'h0D00, 4'd0, 2'b01);
    checks++;
    if (last_bresp !== 2'b10) begin failures++; $display("FAIL long_burst_bresp got=%b want=10", last_bresp); end
    do_read(33'h0D00, 4'd1, 2'b01, 0);
    checks++;
    if (rq_data.size() != 2 || rq_data[0] !== model[104] || rq_data[1] !== model[105]) begin
      failures++; $display("FAIL long_burst_discard beats=%0d", rq_data.size());
    end
    wq_data = '{rnd_word()}; wq_strb = '{'1};
    model_write(33'h0E00, 4'd0, 2'b10, e);
    do_write(33'h0E00, 4'd0, 2'b10);
    checks++;
    if (last_bresp !== 2'b10) begin failures++; $display("FAIL err_write_bresp got=%b want=10", last_bresp); end
    do_read(33'h0E00, 4'd0, 2'b01, 0);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== model[112]) begin failures++; $display("FAIL err_write_nowrite beats=%0d", rq_data.size()); end
    for (int bt = 2; bt < 4; bt++) begin
      do_read(33'h0040, 4'd1, 2'(bt), 0);
      checks++;
      if (rq_data.size() != 2) begin failures++; $display("FAIL err_read_beats burst=%0d got=%0d want=2", bt, rq_data.size()); end
      else for (int k = 0; k < 2; k++) begin
        checks++;
        if (rq_resp[k] !== 2'b10 || rq_data[k] !== '0 || rq_last[k] !== (k == 1)) begin
          failures++; $display("FAIL err_read burst=%0d beat=%0d resp=%b last=%b rdata=%h want resp=10 rdata=0", bt, k, rq_resp[k], rq_last[k], rq_data[k]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_read(33'h1_0000_1FE7, 4'd1, 2'b01, 0);
    checks++;
    if (rq_data.size() != 2 || rq_data[0] !== model[255] || rq_data[1] !== model[0]) begin
      failures++; $display("FAIL wrap_last_word beats=%0d got0=%h want0=%h", rq_data.size(), rq_data.size() > 1 ? rq_data[1] : '0, model[0]);
    end
  endtask

  task automatic test_concurrent();
    logic [255:0] old_w, new_w;
    logic [1:0] e;
    int t;
    old_w = model[48]; new_w = rnd_word();
    io_s_axi_AWADDR = 33'h600; io_s_axi_AWLEN = 0; io_s_axi_AWBURST = 2'b01; io_s_axi_AWVALID = 1;
    t = 0;
    while (!io_s_axi_AWREADY && t < 50) begin @(negedge clock); t++; end
    @(negedge clock);
    io_s_axi_AWVALID = 0;
    io_s_axi_WDATA = new_w; io_s_axi_WSTRB = '1; io_s_axi_WLAST = 1; io_s_axi_WVALID = 1;
    io_s_axi_ARADDR = 33'h600; io_s_axi_ARLEN = 0; io_s_axi_ARBURST = 2'b01; io_s_axi_ARVALID = 1;
    checks++;
    if ({io_s_axi_WREADY, io_s_axi_ARREADY} !== 2'b11) begin
      failures++; $display("FAIL concurrent_ready got=%b want=11", {io_s_axi_WREADY, io_s_axi_ARREADY});
    end
    @(negedge clock);
    io_s_axi_WVALID = 0; io_s_axi_WLAST = 0; io_s_axi_ARVALID = 0;
    checks++;
    if (io_s_axi_RVALID !== 1'b1 || io_s_axi_RDATA !== old_w) begin
      failures++; $display("FAIL concurrent_read_first rvalid=%b got=%h want=%h", io_s_axi_RVALID, io_s_axi_RDATA, old_w);
    end
    checks++;
    if (io_s_axi_BVALID !== 1'b1 || io_s_axi_BRESP !== 2'b00) begin
      failures++; $display("FAIL concurrent_bresp bvalid=%b bresp=%b want 1/00", io_s_axi_BVALID, io_s_axi_BRESP);
    end
    io_s_axi_RREADY = 1; io_s_axi_BREADY = 1;
    @(negedge clock);
    io_s_axi_RREADY = 0; io_s_axi_BREADY = 0;
    wq_data = '{new_w}; wq_strb = '{'1};
    model_write(33'h600, 4'd0, 2'b01, e);
    do_read(33'h600, 4'd0, 2'b01, 0);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== new_w) begin failures++; $display("FAIL concurrent_write_done beats=%0d", rq_data.size()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [3:0] len;
    logic [1:0] burst, e;
    int r, nb;
    for (int it = 0; it < 40; it++) begin
      a = {1'($urandom_range(0, 1)), 32'($urandom)};
      len = 4'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      burst = r < 5 ? 2'b01 : r < 8 ? 2'b00 : {1'b1, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 1)) begin
        nb = $urandom_range(0, 4) == 0 ? $urandom_range(1, int'(len) + 2) : int'(len) + 1;
        wq_data.delete(); wq_strb.delete();
        for (int k = 0; k < nb; k++) begin
          wq_data.push_back(rnd_word());
          wq_strb.push_back($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'($urandom));
        end
        model_write(a, len, burst, e);
        do_write(a, len, burst);
        checks++;
        if (last_bresp !== e) begin failures++; $display("FAIL rand_bresp it=%0d got=%b want=%b", it, last_bresp, e); end
      end else begin
        do_read(a, len, burst, 1);
        checks++;
        if (rq_data.size() != int'(len) + 1) begin failures++; $display("FAIL rand_beats it=%0d got=%0d want=%0d", it, rq_data.size(), len + 1); end
        else for (int k = 0; k <= int'(len); k++) begin
          checks++;
          if (rq_data[k] !== exp_rd(a, k, burst) || rq_last[k] !== (k == int'(len)) || rq_resp[k] !== (burst[1] ? 2'b10 : 2'b00)) begin
            failures++; $display("FAIL rand_read it=%0d beat=%0d got=%h want=%h last=%b resp=%b", it, k, rq_data[k], exp_rd(a, k, burst), rq_last[k], rq_resp[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    io_s_axi_ARADDR = 33'h1400; io_s_axi_ARLEN = 4'd3; io_s_axi_ARBURST = 2'b01; io_s_axi_ARVALID = 1;
    t = 0;
    while (!io_s_axi_ARREADY && t < 50) begin @(negedge clock); t++; end
    @(negedge clock);
    io_s_axi_ARVALID = 0; io_s_axi_RREADY = 1;
    @(negedge clock);
    reset = 0; io_s_axi_RREADY = 0;
    @(negedge clock);
    checks++;
    if (io_s_axi_RVALID !== 1'b0 || io_s_axi_ARREADY !== 1'b0) begin
      failures++; $display("FAIL midreset_abort rvalid=%b arready=%b want 0/0", io_s_axi_RVALID, io_s_axi_ARREADY);
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if ({io_s_axi_ARREADY, io_s_axi_AWREADY, io_s_axi_RVALID, io_s_axi_BVALID} !== 4'b1100) begin
      failures++; $display("FAIL midreset_release got=%b want=1100", {io_s_axi_ARREADY, io_s_axi_AWREADY, io_s_axi_RVALID, io_s_axi_BVALID});
    end
    do_read(33'h1400, 4'd3, 2'b01, 0);
    checks++;
    if (rq_data.size() != 4) begin failures++; $display("FAIL midreset_beats got=%0d want=4", rq_data.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (rq_data[k] !== model[160 + k]) begin failures++; $display("FAIL midreset_preserved beat=%0d got=%h want=%h", k, rq_data[k], model[160 + k]); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_single_write();
    test_incr_read();
    test_backpressure();
    test_strobe();
    test_errors();
    test_wrap();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
